// File: rtl/jk_cmd_pkg.sv
// Shared types for the jklatch command driver: command encoding, FSM states and the
// shadow-q next-state function used by both the RTL and its bench model.
package jk_cmd_pkg;

    localparam int unsigned JK_W = 2;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GUARD
    } state_e;

    typedef struct packed {
        logic vld;
        logic q;
    } shadow_t;

    // Toggle from an unknown latch state leaves it unknown.
    function automatic shadow_t jk_next(input shadow_t cur, input jk_cmd_e cmd);
        shadow_t nxt;
        nxt = cur;
        case (cmd)
            JK_HOLD: nxt = cur;
            JK_RST:  nxt = '{vld: 1'b1, q: 1'b0};
            JK_SET:  nxt = '{vld: 1'b1, q: 1'b1};
            JK_TGL:  nxt.q = cur.vld ? ~cur.q : cur.q;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy count; head is visible on rdata
// whenever the FIFO is non-empty.
module jk_cmd_fifo
    import jk_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = JK_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// Command driver for the jklatch: queues {j,k} commands, drives each for a programmed hold
// with a 00 guard cycle, and tracks expected q. Define JK_SHADOW_CHECK_EN for the q_in check.
module jk_cmd_driver
    import jk_cmd_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd,
    input  logic [HOLD_W-1:0]      cfg_hold,
    output logic                   j,
    output logic                   k,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   shadow_q,
    output logic                   shadow_vld
`ifdef JK_SHADOW_CHECK_EN
    ,
    input  logic                   q_in,
    output logic                   mismatch
`endif
);

    state_e            state_q, state_d;
    jk_cmd_e           cmd_q, cmd_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] issue_hold;
    shadow_t           shd_q, shd_d;
    logic [JK_W-1:0]   jk_q, jk_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [JK_W-1:0]   fifo_rdata;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (JK_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (cmd),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    // Toggle is limited to a single cycle so the transparent latch cannot oscillate for long.
    always_comb begin
        if (jk_cmd_e'(fifo_rdata) == JK_TGL || cfg_hold == '0) begin
            issue_hold = HOLD_W'(1);
        end else begin
            issue_hold = cfg_hold;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        hold_d   = hold_q;
        shd_d    = shd_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            S_IDLE, S_GUARD: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_DRIVE;
                    cmd_d    = jk_cmd_e'(fifo_rdata);
                    hold_d   = issue_hold;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = S_GUARD;
                    shd_d   = jk_next(shd_q, cmd_q);
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pins are registered off the current state, so they trail the FSM by one cycle.
    assign jk_d = (state_q == S_DRIVE) ? cmd_q : JK_HOLD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= JK_HOLD;
            hold_q  <= '0;
            shd_q   <= '0;
            jk_q    <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            hold_q  <= hold_d;
            shd_q   <= shd_d;
            jk_q    <= jk_d;
        end
    end

    assign j          = jk_q[1];
    assign k          = jk_q[0];
    assign shadow_q   = shd_q.q;
    assign shadow_vld = shd_q.vld;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;

`ifdef JK_SHADOW_CHECK_EN
    logic mismatch_q;

    // Compare in the guard cycle, after the shadow has taken the command's effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (state_q == S_GUARD && shd_q.vld && (q_in != shd_q.q)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Scoreboard bench for jk_cmd_driver: stimulus queues hand-computed drive episodes,
// a monitor closes each j/k episode and compares it. JK_SHADOW_CHECK_EN adds mismatch checks.
module tb_jk_cmd_driver;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned HOLD_W = 4;

    logic                   clk;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd;
    logic [HOLD_W-1:0]      cfg_hold;
    logic                   j;
    logic                   k;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   shadow_q;
    logic                   shadow_vld;
`ifdef JK_SHADOW_CHECK_EN
    logic                   q_in;
    logic                   mismatch;
`endif

    typedef struct {
        logic [1:0] ecmd;
        int         elen;
        logic       eq;
        logic       evld;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    jk_cmd_driver #(
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .cfg_hold   (cfg_hold),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .fifo_cnt   (fifo_cnt),
        .shadow_q   (shadow_q),
        .shadow_vld (shadow_vld)
`ifdef JK_SHADOW_CHECK_EN
        ,
        .q_in       (q_in),
        .mismatch   (mismatch)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push one command; optionally queue the episode the monitor should see for it.
    task automatic push(input logic [1:0] c, input bit track, input int len,
                        input logic eq, input logic ev);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("push ready timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd       = c;
        if (track) sb.push_back('{ecmd: c, elen: len, eq: eq, evld: ev});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = ~c;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 100);
        if (busy) check("idle timeout", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst j", 32'(j), 32'd0);
        check("rst k", 32'(k), 32'd0);
        check("rst fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst shadow_q", 32'(shadow_q), 32'd0);
        check("rst shadow_vld", 32'(shadow_vld), 32'd0);
`ifdef JK_SHADOW_CHECK_EN
        check("rst mismatch", 32'(mismatch), 32'd0);
`endif
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: a drive episode is a run of identical non-zero j/k samples ended by 00.
    initial begin : monitor
        logic [1:0] cur;
        int         run;
        exp_t       e;
        cur = 2'b00;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else if ({j, k} != 2'b00) begin
                if (run != 0 && {j, k} != cur) check("guard gap", 32'({j, k}), 32'(cur));
                cur = {j, k};
                run++;
            end else if (run != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected drive", 32'(cur), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("drive cmd", 32'(cur), 32'(e.ecmd));
                    check("drive len", run, e.elen);
                    check("shadow vld", 32'(shadow_vld), 32'(e.evld));
                    if (e.evld) check("shadow q", 32'(shadow_q), 32'(e.eq));
                end
                run = 0;
            end
        end
    end

    initial begin : stimulus
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        cfg_hold  = 4'd3;
`ifdef JK_SHADOW_CHECK_EN
        q_in      = 1'b0;
`endif
        #13;
        apply_reset();

        // Single set, hold 3: latency and episode timing.
        push(2'b10, 1'b1, 3, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("lat n+1 jk", 32'({j, k}), 32'd0);
        check("pop at n+1", 32'(fifo_cnt), 32'd0);
        @(posedge clk); #1;
        check("lat n+2 jk", 32'({j, k}), 32'b10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hold n+4 jk", 32'({j, k}), 32'b10);
        check("busy n+4", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("guard n+5 jk", 32'({j, k}), 32'd0);
        @(posedge clk); #1;
        check("busy n+6", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
`ifdef JK_SHADOW_CHECK_EN
        check("mismatch sticky", 32'(mismatch), 32'd1);
`endif

        // Toggle after set ignores cfg_hold.
        cfg_hold = 4'd5;
        push(2'b11, 1'b1, 1, 1'b0, 1'b1);
        wait_idle();

        // Reset in the middle of a long set.
        cfg_hold = 4'd8;
        push(2'b10, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset drive", 32'({j, k}), 32'b10);
        apply_reset();

        // Toggle from unknown keeps shadow unknown.
        push(2'b11, 1'b1, 1, 1'b0, 1'b0);
        wait_idle();

        // Hold-time boundaries, then a hold command that must leave the shadow alone.
        cfg_hold = 4'd0;
        push(2'b10, 1'b1, 1, 1'b1, 1'b1);
        wait_idle();
        cfg_hold = 4'd15;
        push(2'b01, 1'b1, 15, 1'b0, 1'b1);
        wait_idle();
        cfg_hold = 4'd2;
        push(2'b00, 1'b0, 0, 1'b0, 1'b0);
        wait_idle();
        check("hold keeps q", 32'(shadow_q), 32'd0);
        check("hold keeps vld", 32'(shadow_vld), 32'd1);

        // Back-to-back pushes fill the FIFO while the first command drives.
        cfg_hold = 4'd4;
        push(2'b10, 1'b1, 4, 1'b1, 1'b1);
        push(2'b01, 1'b1, 4, 1'b0, 1'b1);
        check("push+pop cnt", 32'(fifo_cnt), 32'd1);
        push(2'b11, 1'b1, 1, 1'b1, 1'b1);
        push(2'b11, 1'b1, 1, 1'b0, 1'b1);
        push(2'b10, 1'b1, 4, 1'b1, 1'b1);
        check("full cnt", 32'(fifo_cnt), 32'd4);
        check("full ready", 32'(cmd_ready), 32'd0);
        push(2'b01, 1'b1, 4, 1'b0, 1'b1);
        check("refill cnt", 32'(fifo_cnt), 32'd4);
        wait_idle();

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
